uart_tx: RTL and testbench

UART serial transmitter: accepts one parallel byte per valid/ready handshake and shifts it out on `tx` as a standard asynchronous frame (start bit, DATA_BITS data bits LSB-first, optional parity, 1 or 2 stop bits). Sits directly downstream of the baud-rate generator. Bit boundaries are driven solely by its single-cycle `baud_tick` enable, so this block contains no baud divider. Feeds the board-level TX pin.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_tx.sv | 158 +++++++++++++++
 tb/tb_uart_tx.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART transmitter and the future receiver.
//
// Contents:
//   uart_state_t    frame-sequencing state encoding (IDLE, ARM, START, DATA, PARITY, STOP)
//   STOP_BITS_*     the legal stop-bit counts
//   DATA_BITS_*     the legal range of data bits per frame
//   parity_calc()   parity bit of a data word; even or odd selected by the caller
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_state_t;

  localparam int STOP_BITS_ONE = 1;
  localparam int STOP_BITS_TWO = 2;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 8;

  // The caller zero-extends narrower words, so the unused upper bits do not
  // change the XOR reduction.
  function automatic logic parity_calc(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx -- UART serial transmitter driven by an external baud enable.
//
// Accepts one word per valid/ready handshake. It sends the word on tx as:
//   start bit (0), DATA_BITS data bits LSB-first, optional parity bit, and
//   STOP_BITS stop bits (1).
// Bit boundaries come only from baud_tick. This block contains no divider.
//
// Parameters:
//   DATA_BITS   data bits per frame, 5..8
//   STOP_BITS   stop bits per frame, 1 or 2
//   PARITY_EN   1 = append a parity bit after the data bits
//   PARITY_ODD  with PARITY_EN=1: 1 = odd parity, 0 = even parity
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset; aborts any frame in flight
//   baud_tick  one-clk pulse per bit period
//   tx_data    word to send, sampled on the handshake
//   tx_valid   upstream has a word
//   tx_ready   high only while idle
//   tx         serial line, idle high, registered
//   tx_busy    high from the cycle after acceptance until the return to idle
//   tx_done    one-clk pulse as the last stop bit completes
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  generate
    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
      $error("uart_tx: DATA_BITS must be in 5..8");
    end
    if (STOP_BITS != STOP_BITS_ONE && STOP_BITS != STOP_BITS_TWO) begin : g_bad_stop_bits
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_t          state_reg;
  logic [DATA_BITS-1:0] shreg_reg;
  logic                 parity_reg;
  logic [2:0]           bit_cnt_reg;
  logic                 stop_cnt_reg;
  logic                 tx_reg;
  logic                 ready_reg;
  logic                 busy_reg;
  logic                 done_reg;

  logic [7:0] data_ext;
  assign data_ext = 8'(tx_data);

  assign tx       = tx_reg;
  assign tx_ready = ready_reg;
  assign tx_busy  = busy_reg;
  assign tx_done  = done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      shreg_reg    <= '0;
      parity_reg   <= 1'b0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      tx_reg       <= 1'b1;
      ready_reg    <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // A tick arriving in the acceptance cycle is ignored here. ARM
          // then waits for the next tick, so the start bit lasts a full period.
          if (tx_valid && ready_reg) begin
            shreg_reg    <= tx_data;
            parity_reg   <= parity_calc(data_ext, PARITY_ODD != 0);
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (baud_tick) begin
            tx_reg    <= 1'b0;
            state_reg <= ST_START;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            tx_reg    <= shreg_reg[0];
            state_reg <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (bit_cnt_reg == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                tx_reg    <= parity_reg;
                state_reg <= ST_PARITY;
              end else begin
                tx_reg    <= 1'b1;
                state_reg <= ST_STOP;
              end
            end else begin
              // The bit now on the line is shreg[0]. Load the next one while shifting.
              tx_reg      <= shreg_reg[1];
              shreg_reg   <= shreg_reg >> 1;
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (baud_tick) begin
            tx_reg    <= 1'b1;
            state_reg <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (baud_tick) begin
            if (stop_cnt_reg == LAST_STOP) begin
              ready_reg <= 1'b1;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= ST_IDLE;
            end else begin
              stop_cnt_reg <= stop_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          tx_reg    <= 1'b1;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed, table-driven bench for uart_tx.
//
// Four instances share the clock, reset and baud_tick, which pulses every 4 clks:
//   unit 0: 8N1   unit 1: 8E1   unit 2: 8O1   unit 3: 8N2
// Each frame is recorded cycle by cycle and then decoded against a hand-computed
// frame word. Bit k of the frame word is the k-th bit on the line, starting with the start bit.
module tb_uart_tx;

  localparam int TRACE_N = 100;

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic [7:0] tx_data_a [4];
  logic [3:0] tx_valid_a;
  logic [3:0] tx_ready_w;
  logic [3:0] tx_w;
  logic [3:0] tx_busy_w;
  logic [3:0] tx_done_w;

  int tick_phase;
  int checks;
  int failures;

  logic tr_tx    [TRACE_N];
  logic tr_ready [TRACE_N];
  logic tr_busy  [TRACE_N];
  logic tr_done  [TRACE_N];

  typedef struct {
    int          unit;
    logic [7:0]  data;
    int          nbits;
    logic [15:0] frame;
    int          align;
    bit          inject;
  } vec_t;

  vec_t vecs [7];

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data_a[0]), .tx_valid(tx_valid_a[0]),
    .tx_ready(tx_ready_w[0]), .tx(tx_w[0]), .tx_busy(tx_busy_w[0]), .tx_done(tx_done_w[0]));
  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data_a[1]), .tx_valid(tx_valid_a[1]),
    .tx_ready(tx_ready_w[1]), .tx(tx_w[1]), .tx_busy(tx_busy_w[1]), .tx_done(tx_done_w[1]));
  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data_a[2]), .tx_valid(tx_valid_a[2]),
    .tx_ready(tx_ready_w[2]), .tx(tx_w[2]), .tx_busy(tx_busy_w[2]), .tx_done(tx_done_w[2]));
  uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_EN(0), .PARITY_ODD(0)) u_dut3 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data_a[3]), .tx_valid(tx_valid_a[3]),
    .tx_ready(tx_ready_w[3]), .tx(tx_w[3]), .tx_busy(tx_busy_w[3]), .tx_done(tx_done_w[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // baud_tick is high for the posedge that follows a negedge where the phase wraps to 0.
  initial begin
    tick_phase = 0;
    baud_tick  = 1'b0;
    forever begin
      @(negedge clk);
      tick_phase = (tick_phase + 1) % 4;
      baud_tick  = (tick_phase == 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Sample index 0 is the cycle right after the handshake edge.
  task automatic capture(input int u);
    for (int i = 0; i < TRACE_N; i++) begin
      @(negedge clk);
      tr_tx[i]    = tx_w[u];
      tr_ready[i] = tx_ready_w[u];
      tr_busy[i]  = tx_busy_w[u];
      tr_done[i]  = tx_done_w[u];
    end
  endtask

  // Lands just after a negedge whose tick phase is 'align', before the next posedge.
  task automatic wait_phase(input int align);
    @(negedge clk);
    #1;
    while (tick_phase != align) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic analyze(input int from, input int nbits, input logic [15:0] exp,
                         input int exp_start, input string name, output int done_idx);
    int s;
    int e;
    int unstable;
    int ready_hi;
    int busy_lo;
    int dones;
    logic [15:0] got;
    s = -1;
    done_idx = -1;
    for (int i = from; i < TRACE_N; i++) begin
      if (!tr_tx[i]) begin
        s = i;
        break;
      end
    end
    check({name, " start_idx"}, s, exp_start);
    if (s < 0 || s + 4 * nbits + 1 >= TRACE_N) return;
    e = s + 4 * nbits;
    got = '0;
    unstable = 0;
    for (int k = 0; k < nbits; k++) begin
      got[k] = tr_tx[s + 4 * k];
      for (int j = 1; j < 4; j++)
        if (tr_tx[s + 4 * k + j] !== tr_tx[s + 4 * k]) unstable++;
    end
    check({name, " frame"}, got, exp);
    check({name, " bit_hold"}, unstable, 0);
    ready_hi = 0;
    busy_lo = 0;
    for (int i = from; i < e; i++) begin
      if (tr_ready[i]) ready_hi++;
      if (!tr_busy[i]) busy_lo++;
    end
    check({name, " ready_low"}, ready_hi, 0);
    check({name, " busy_high"}, busy_lo, 0);
    check({name, " end_flags"}, {tr_done[e], tr_ready[e], tr_busy[e]}, 3'b110);
    dones = 0;
    for (int i = from; i <= e + 1; i++)
      if (tr_done[i]) dones++;
    check({name, " done_count"}, dones, 1);
    done_idx = e;
  endtask

  task automatic send_frame(input int u, input logic [7:0] d, input int nbits, input logic [15:0] exp,
                            input int align, input bit inject, input string name);
    int done_idx;
    int lows;
    wait_phase(align);
    tx_valid_a[u] = 1'b1;
    tx_data_a[u]  = d;
    fork
      capture(u);
      begin
        @(negedge clk);
        tx_valid_a[u] = 1'b0;
        tx_data_a[u]  = ~d;
        if (inject) begin
          repeat (12) @(negedge clk);
          tx_valid_a[u] = 1'b1;
          tx_data_a[u]  = 8'h99;
          @(negedge clk);
          tx_valid_a[u] = 1'b0;
        end
      end
    join
    analyze(0, nbits, exp, (align == 0) ? 4 : 4 - align, name, done_idx);
    if (inject && done_idx >= 0) begin
      lows = 0;
      for (int i = done_idx; i < TRACE_N; i++)
        if (!tr_tx[i]) lows++;
      check({name, " quiet_after"}, lows, 0);
    end
  endtask

  int d1;
  int d2;
  int waited;
  int dones;
  int lows;

  initial begin
    vecs[0] = '{0, 8'h55, 10, 16'h02AA, 0, 1'b0};
    vecs[1] = '{0, 8'hFF, 10, 16'h03FE, 1, 1'b0};
    vecs[2] = '{1, 8'h07, 11, 16'h060E, 2, 1'b0};
    vecs[3] = '{1, 8'h00, 11, 16'h0400, 3, 1'b0};
    vecs[4] = '{2, 8'h07, 11, 16'h040E, 0, 1'b0};
    vecs[5] = '{3, 8'hA3, 11, 16'h0746, 1, 1'b0};
    vecs[6] = '{0, 8'h3C, 10, 16'h0278, 2, 1'b1};

    checks = 0;
    failures = 0;
    rst = 1'b1;
    tx_valid_a = '0;
    for (int i = 0; i < 4; i++) tx_data_a[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 4; u++)
      check($sformatf("reset_u%0d", u), {tx_w[u], tx_ready_w[u], tx_busy_w[u], tx_done_w[u]}, 4'b1100);

    for (int i = 0; i < 7; i++)
      send_frame(vecs[i].unit, vecs[i].data, vecs[i].nbits, vecs[i].frame, vecs[i].align,
                 vecs[i].inject, $sformatf("vec%0d", i));

    // Back-to-back: valid held high, second word accepted in the tx_done cycle.
    wait_phase(3);
    tx_valid_a[0] = 1'b1;
    tx_data_a[0]  = 8'h12;
    fork
      capture(0);
      begin
        @(negedge clk);
        tx_data_a[0] = 8'h34;
        for (int i = 0; i < TRACE_N; i++) begin
          if (tx_done_w[0]) break;
          @(negedge clk);
        end
        @(negedge clk);
        tx_valid_a[0] = 1'b0;
      end
    join
    analyze(0, 10, 16'h0224, 1, "b2b_first", d1);
    if (d1 >= 0) analyze(d1 + 1, 10, 16'h0268, d1 + 4, "b2b_second", d2);

    // Reset in the middle of the data bits of 0xFF.
    wait_phase(1);
    tx_valid_a[0] = 1'b1;
    tx_data_a[0]  = 8'hFF;
    @(negedge clk);
    tx_valid_a[0] = 1'b0;
    waited = 0;
    while (tx_w[0] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("rst_start_seen", tx_w[0], 1'b0);
    repeat (10) @(negedge clk);
    check("rst_pre_busy", tx_busy_w[0], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort", {tx_w[0], tx_ready_w[0], tx_busy_w[0], tx_done_w[0]}, 4'b1100);
    rst = 1'b0;
    dones = 0;
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_done_w[0]) dones++;
      if (!tx_w[0]) lows++;
    end
    check("rst_no_done", dones, 0);
    check("rst_idle_tx", lows, 0);
    send_frame(0, 8'h00, 10, 16'h0200, 2, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
